spdif_sample_scheduler: RTL

// Sequences audio samples into the S/PDIF subframe assembler.

---
 rtl/spdif_sample_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spdif_sample_scheduler.sv
// Sequences left/right samples into the S/PDIF subframe assembler: pops L/R pairs on channel-A requests,
// tracks the channel-status block position, flags underruns, and starts/stops only on frame boundaries.
module spdif_sample_scheduler #(
    parameter int                   DATA_W    = 20,
    parameter int                   BLOCK_LEN = 192,
    parameter logic [BLOCK_LEN-1:0] CS_BITS   = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] l_data,
    input  logic              l_valid,
    output logic              l_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic              sf_req,
    input  logic              sf_chan,
    output logic [DATA_W-1:0] word,
    output logic              v_flag,
    output logic              cs_bit,
    output logic              block_start,
    output logic              tx_run,
    output logic              seq_err,
    output logic [CNT_W-1:0]  underrun_cnt
);

    localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic                serve, drain_done;
    logic                serve_a, serve_b, pair_ok;
    logic [IDX_W-1:0]    frame_idx_reg;
    logic [IDX_W-1:0]    cs_idx;
    logic                frame_last;
    logic                exp_chan_reg;
    logic [DATA_W-1:0]   hold_r_reg;
    logic [DATA_W-1:0]   word_reg;
    logic                v_flag_reg, cs_bit_reg, tx_run_reg, seq_err_reg, pop_reg;
    logic [CNT_W-1:0]    underrun_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // In DRAIN the first channel-A request ends the run instead of being served,
    // so a stopped stream never leaves half a frame behind.
    always_comb begin
        state_next = state_reg;
        serve      = 1'b0;
        drain_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable)                 state_next = IDLE;
                else if (l_valid && r_valid) state_next = RUN;
            end
            RUN: begin
                serve = sf_req;
                if (!enable) state_next = DRAIN;
            end
            DRAIN: begin
                if (sf_req) begin
                    if (sf_chan) begin
                        serve = 1'b1;
                    end else begin
                        drain_done = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign serve_a    = serve && !sf_chan;
    assign serve_b    = serve && sf_chan;
    assign pair_ok    = l_valid && r_valid;
    assign cs_idx     = IDX_W'(BLOCK_LEN - 1) - frame_idx_reg;
    assign frame_last = (frame_idx_reg == IDX_W'(BLOCK_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_reg          <= 1'b0;
            word_reg         <= '0;
            hold_r_reg       <= '0;
            v_flag_reg       <= 1'b1;
            cs_bit_reg       <= CS_BITS[BLOCK_LEN-1];
            frame_idx_reg    <= '0;
            exp_chan_reg     <= 1'b0;
            tx_run_reg       <= 1'b0;
            seq_err_reg      <= 1'b0;
            underrun_cnt_reg <= '0;
        end else begin
            pop_reg <= serve_a && pair_ok;
            if (state_reg == RUN) tx_run_reg <= 1'b1;

            if (drain_done) begin
                tx_run_reg    <= 1'b0;
                word_reg      <= '0;
                hold_r_reg    <= '0;
                v_flag_reg    <= 1'b1;
                frame_idx_reg <= '0;
                exp_chan_reg  <= 1'b0;
            end

            if (serve) begin
                // A mismatched request resyncs the expected channel to what was actually asked for.
                exp_chan_reg <= ~sf_chan;
                if (sf_chan != exp_chan_reg) seq_err_reg <= 1'b1;
            end

            if (serve_a) begin
                cs_bit_reg <= CS_BITS[cs_idx];
                if (pair_ok) begin
                    word_reg   <= l_data;
                    hold_r_reg <= r_data;
                    v_flag_reg <= 1'b0;
                end else begin
                    word_reg   <= '0;
                    hold_r_reg <= '0;
                    v_flag_reg <= 1'b1;
                    if (underrun_cnt_reg != {CNT_W{1'b1}})
                        underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
                end
            end

            if (serve_b) begin
                word_reg      <= hold_r_reg;
                frame_idx_reg <= frame_last ? '0 : frame_idx_reg + 1'b1;
            end
        end
    end

    assign l_ready      = pop_reg;
    assign r_ready      = pop_reg;
    assign word         = word_reg;
    assign v_flag       = v_flag_reg;
    assign cs_bit       = cs_bit_reg;
    assign block_start  = (frame_idx_reg == '0);
    assign tx_run       = tx_run_reg;
    assign seq_err      = seq_err_reg;
    assign underrun_cnt = underrun_cnt_reg;

endmodule
